// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit pipeline: widths, opcodes, instruction
// field positions, the bubble word and the per-opcode control decode.
package mips16_pkg;

   localparam int DW  = 16;
   localparam int RAW = 3;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;
   localparam logic [3:0] OP_BEQZ = 4'h8;
   localparam logic [3:0] OP_BNEZ = 4'h9;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS_HI  = 8;
   localparam int RS_LO  = 6;
   localparam int RT_HI  = 5;
   localparam int RT_LO  = 3;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;
   localparam int FN_HI  = 2;
   localparam int FN_LO  = 0;

   localparam logic [DW-1:0] NOP_WORD = 16'h0000;

   // Control bits implied by an opcode alone.
   typedef struct packed {
      logic legal;
      logic uses_rs;
      logic uses_rt;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic is_branch;
   } dec_t;

   // IF/ID pipeline register contents.
   typedef struct packed {
      logic          valid;
      logic [DW-1:0] instr;
      logic [DW-1:0] pc;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
   } ifid_t;

   // ID/EX pipeline register contents.
   typedef struct packed {
      logic           valid;
      logic [DW-1:0]  pc;
      logic [3:0]     opcode;
      logic [2:0]     funct;
      logic [DW-1:0]  a;
      logic [DW-1:0]  b;
      logic [DW-1:0]  imm;
      logic [RAW-1:0] waddr;
      logic           reg_write;
      logic           mem_read;
      logic           mem_write;
   } idex_t;

   // Unknown opcodes fall through to the all-zero NOP decode.
   function automatic dec_t decode_op(input logic [3:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_NOP: d = '0;
         OP_ALU: begin
            d.legal     = 1'b1;
            d.uses_rs   = 1'b1;
            d.uses_rt   = 1'b1;
            d.reg_write = 1'b1;
         end
         OP_ADDI: begin
            d.legal     = 1'b1;
            d.uses_rs   = 1'b1;
            d.reg_write = 1'b1;
         end
         OP_LW: begin
            d.legal     = 1'b1;
            d.uses_rs   = 1'b1;
            d.reg_write = 1'b1;
            d.mem_read  = 1'b1;
         end
         OP_SW: begin
            d.legal     = 1'b1;
            d.uses_rs   = 1'b1;
            d.uses_rt   = 1'b1;
            d.mem_write = 1'b1;
         end
         OP_BEQZ, OP_BNEZ: begin
            d.legal     = 1'b1;
            d.uses_rs   = 1'b1;
            d.is_branch = 1'b1;
         end
         default: d = '0;
      endcase
      return d;
   endfunction

   function automatic logic [DW-1:0] sext6(input logic [5:0] imm);
      return {{(DW-6){imm[5]}}, imm};
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bus between the decode stage and its neighbours: fetch-side inputs and
// controls, the EX/MEM destination report, and the ID/EX register outputs.
// master = surrounding pipeline, slave = id_stage.
interface id_stage_if;

   logic [mips16_pkg::DW-1:0]  if_instruction;
   logic [mips16_pkg::DW-1:0]  if_pc;
   logic [mips16_pkg::DW-1:0]  rf_rd1;
   logic [mips16_pkg::DW-1:0]  rf_rd2;
   logic                       exmem_reg_write;
   logic [mips16_pkg::RAW-1:0] exmem_waddr;
   logic                       mem_stall;

   logic                       pc_enable;
   logic                       branch_enable;
   logic [mips16_pkg::DW-1:0]  pc_branched;
   logic [5:0]                 imm_pc_offset;

   logic                       idex_valid;
   logic [mips16_pkg::DW-1:0]  idex_pc;
   logic [3:0]                 idex_opcode;
   logic [2:0]                 idex_funct;
   logic [mips16_pkg::DW-1:0]  idex_a;
   logic [mips16_pkg::DW-1:0]  idex_b;
   logic [mips16_pkg::DW-1:0]  idex_imm;
   logic [mips16_pkg::RAW-1:0] idex_waddr;
   logic                       idex_reg_write;
   logic                       idex_mem_read;
   logic                       idex_mem_write;

   modport master (
      output if_instruction, if_pc, rf_rd1, rf_rd2,
      output exmem_reg_write, exmem_waddr, mem_stall,
      input  pc_enable, branch_enable, pc_branched, imm_pc_offset,
      input  idex_valid, idex_pc, idex_opcode, idex_funct, idex_a, idex_b,
      input  idex_imm, idex_waddr, idex_reg_write, idex_mem_read, idex_mem_write
   );

   modport slave (
      input  if_instruction, if_pc, rf_rd1, rf_rd2,
      input  exmem_reg_write, exmem_waddr, mem_stall,
      output pc_enable, branch_enable, pc_branched, imm_pc_offset,
      output idex_valid, idex_pc, idex_opcode, idex_funct, idex_a, idex_b,
      output idex_imm, idex_waddr, idex_reg_write, idex_mem_read, idex_mem_write
   );

endinterface

// File: rtl/id_stage_hazard_unit.sv
// Read-after-write interlock for the instruction being fetched. The register
// file is write-through, so only writers still in IF/ID, ID/EX or EX/MEM can
// supply stale operands; once a writer leaves EX/MEM the stall drops.
module hazard_unit
   import mips16_pkg::*;
(
   input  logic [3:0]     if_opcode,
   input  logic [RAW-1:0] if_rs,
   input  logic [RAW-1:0] if_rt,
   input  logic           ifid_write,
   input  logic [RAW-1:0] ifid_waddr,
   input  logic           idex_write,
   input  logic [RAW-1:0] idex_waddr,
   input  logic           exmem_write,
   input  logic [RAW-1:0] exmem_waddr,
   output logic           stall
);

   dec_t if_dec;
   logic hit_ifid;
   logic hit_idex;
   logic hit_exmem;

   // Compare every source the fetched opcode actually reads against each writer.
   always_comb begin
      if_dec    = decode_op(if_opcode);
      hit_ifid  = ifid_write &&
                  ((if_dec.uses_rs && (if_rs == ifid_waddr)) ||
                   (if_dec.uses_rt && (if_rt == ifid_waddr)));
      hit_idex  = idex_write &&
                  ((if_dec.uses_rs && (if_rs == idex_waddr)) ||
                   (if_dec.uses_rt && (if_rt == idex_waddr)));
      hit_exmem = exmem_write &&
                  ((if_dec.uses_rs && (if_rs == exmem_waddr)) ||
                   (if_dec.uses_rt && (if_rt == exmem_waddr)));
      stall     = hit_ifid || hit_idex || hit_exmem;
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: owns IF/ID and ID/EX, resolves BEQZ/BNEZ in ID and stalls
// fetch on register hazards. Priority: reset, memory stall, taken branch,
// hazard stall, normal advance.
module id_stage
   import mips16_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   id_stage_if.slave bus
);

   ifid_t         ifid_q;
   ifid_t         ifid_d;
   idex_t         idex_q;
   idex_t         idex_d;

   dec_t          ifid_dec;
   logic [3:0]    ifid_op;
   logic          taken;
   logic [DW-1:0] target;
   logic          hz_stall;

   hazard_unit u_hazard (
      .if_opcode   (bus.if_instruction[OP_HI:OP_LO]),
      .if_rs       (bus.if_instruction[RS_HI:RS_LO]),
      .if_rt       (bus.if_instruction[RT_HI:RT_LO]),
      .ifid_write  (ifid_q.valid && ifid_dec.reg_write),
      .ifid_waddr  (ifid_q.instr[RD_HI:RD_LO]),
      .idex_write  (idex_q.reg_write),
      .idex_waddr  (idex_q.waddr),
      .exmem_write (bus.exmem_reg_write),
      .exmem_waddr (bus.exmem_waddr),
      .stall       (hz_stall)
   );

   // Decode the IF/ID instruction and resolve its branch from the latched rs data.
   always_comb begin
      ifid_op  = ifid_q.instr[OP_HI:OP_LO];
      ifid_dec = decode_op(ifid_op);
      taken    = ifid_q.valid && ifid_dec.is_branch &&
                 (((ifid_op == OP_BEQZ) && (ifid_q.rd1 == '0)) ||
                  ((ifid_op == OP_BNEZ) && (ifid_q.rd1 != '0)));
      target   = ifid_q.pc + 16'd1 + sext6(ifid_q.instr[IMM_HI:IMM_LO]);
   end

   // Fetch controls; a taken branch overrides a hazard because the fetched
   // instruction is squashed anyway.
   always_comb begin
      bus.pc_enable     = rst || (!bus.mem_stall && (taken || !hz_stall));
      bus.branch_enable = !rst && !bus.mem_stall && taken;
      bus.pc_branched   = bus.branch_enable ? target : '0;
      bus.imm_pc_offset = ifid_q.instr[IMM_HI:IMM_LO];
   end

   // Next-state for both pipeline registers; mem_stall freezes them.
   always_comb begin
      ifid_d = ifid_q;
      idex_d = idex_q;
      if (!bus.mem_stall) begin
         idex_d = '0;
         if (ifid_q.valid && ifid_dec.legal) begin
            idex_d.valid     = 1'b1;
            idex_d.pc        = ifid_q.pc;
            idex_d.opcode    = ifid_op;
            idex_d.funct     = ifid_q.instr[FN_HI:FN_LO];
            idex_d.a         = ifid_q.rd1;
            idex_d.b         = ifid_q.rd2;
            idex_d.imm       = sext6(ifid_q.instr[IMM_HI:IMM_LO]);
            idex_d.waddr     = ifid_q.instr[RD_HI:RD_LO];
            idex_d.reg_write = ifid_dec.reg_write;
            idex_d.mem_read  = ifid_dec.mem_read;
            idex_d.mem_write = ifid_dec.mem_write;
         end
         if (taken || hz_stall) begin
            ifid_d       = '0;
            ifid_d.instr = NOP_WORD;
         end else begin
            ifid_d.valid = 1'b1;
            ifid_d.instr = bus.if_instruction;
            ifid_d.pc    = bus.if_pc;
            ifid_d.rd1   = bus.rf_rd1;
            ifid_d.rd2   = bus.rf_rd2;
         end
      end
   end

   // Pipeline registers; reset leaves bubbles in both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_q <= '0;
         idex_q <= '0;
      end else begin
         ifid_q <= ifid_d;
         idex_q <= idex_d;
      end
   end

   // ID/EX register fields onto the bus.
   always_comb begin
      bus.idex_valid     = idex_q.valid;
      bus.idex_pc        = idex_q.pc;
      bus.idex_opcode    = idex_q.opcode;
      bus.idex_funct     = idex_q.funct;
      bus.idex_a         = idex_q.a;
      bus.idex_b         = idex_q.b;
      bus.idex_imm       = idex_q.imm;
      bus.idex_waddr     = idex_q.waddr;
      bus.idex_reg_write = idex_q.reg_write;
      bus.idex_mem_read  = idex_q.mem_read;
      bus.idex_mem_write = idex_q.mem_write;
   end

endmodule
